bbs_seq: RTL and testbench

- Blum-Blum-Shub sequencer sitting directly upstream of, and consuming the results of, the radix-2 Montgomery multiplier (mr2mmm plus its controller).
- Loads seed x0, modulus N and R^2 mod N (R = 2^M), converts x0 into the Montgomery domain, then repeatedly squares.
- After each square it converts the value back to the normal domain and emits LSB(x_i) on a valid/ready bit stream.
- Drives the multiplier over a start/done operand handshake; owns no arithmetic beyond range checks.

---
 rtl/bbs_pkg.sv | 21 ++
 rtl/bbs_param_chk.sv | 17 +
 rtl/bbs_seq.sv | 197 +++++++++++++++++++
 tb/tb_bbs_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbs_pkg.sv
// Shared types and constants for the Blum-Blum-Shub sequencer.
package bbs_pkg;

    localparam int unsigned M_DEF  = 8;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [M_DEF-1:0] ONE_M = M_DEF'(1);

    typedef enum logic [2:0] {
        IDLE,
        TO_MONT,
        W_TM,
        SQ,
        W_SQ,
        FM,
        W_FM,
        EMIT
    } bbs_state_e;

endpackage

// File: rtl/bbs_param_chk.sv
// Combinational sanity check of a seed/modulus pair before it is accepted.
module bbs_param_chk
    import bbs_pkg::*;
#(
    parameter int unsigned M = M_DEF
) (
    input  logic [M-1:0] seed,
    input  logic [M-1:0] n_mod,
    output logic         param_err_c
);

    // Modulus must be odd (Montgomery needs gcd(R,N)=1); seed must lie in [2, N).
    always_comb begin
        param_err_c = (n_mod[0] == 1'b0) || (seed < M'(2)) || (seed >= n_mod);
    end

endmodule

// File: rtl/bbs_seq.sv
// Blum-Blum-Shub bit sequencer driving a radix-2 Montgomery multiplier.
// Optional BBS_BYTE_EN packs eight bits MSB-first into byte_out per handshake.
module bbs_seq
    import bbs_pkg::*;
#(
    parameter int unsigned M = M_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_load,
    input  logic [M-1:0] seed,
    input  logic [M-1:0] n_mod,
    input  logic [M-1:0] r2,
    input  logic         gen_en,
    output logic         mm_start,
    output logic [M-1:0] mm_a,
    output logic [M-1:0] mm_b,
    output logic [M-1:0] mm_n,
    input  logic         mm_done,
    input  logic [M-1:0] mm_res,
    output logic         bit_out,
    output logic         bit_valid,
    input  logic         bit_ready,
    output logic         busy,
    output logic         err
`ifdef BBS_BYTE_EN
    ,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid
`endif
);

    bbs_state_e   state, state_d;
    logic [M-1:0] xm, xm_d;
    logic [M-1:0] n_d, a_d, b_d;
    logic         start_d, bit_out_d, bit_valid_d, busy_d, err_d;
    logic         param_err_c;

`ifdef BBS_BYTE_EN
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [BYTE_W-2:0] sh, sh_d;
    logic [BYTE_W-1:0] byte_out_d;
    logic              byte_valid_d;
`endif

    bbs_param_chk #(.M(M)) u_param_chk (
        .seed        (seed),
        .n_mod       (n_mod),
        .param_err_c (param_err_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            xm        <= '0;
            mm_n      <= '0;
            mm_a      <= '0;
            mm_b      <= '0;
            mm_start  <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
`ifdef BBS_BYTE_EN
            cnt        <= '0;
            sh         <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            xm        <= xm_d;
            mm_n      <= n_d;
            mm_a      <= a_d;
            mm_b      <= b_d;
            mm_start  <= start_d;
            bit_out   <= bit_out_d;
            bit_valid <= bit_valid_d;
            busy      <= busy_d;
            err       <= err_d;
`ifdef BBS_BYTE_EN
            cnt        <= cnt_d;
            sh         <= sh_d;
            byte_out   <= byte_out_d;
            byte_valid <= byte_valid_d;
`endif
        end
    end

    // Outputs are registered from the transition, so mm_start is high exactly
    // during the issue state and operands stay put until the next issue.
    // mm_b carries the latched R^2 mod N through TO_MONT/W_TM.
    always_comb begin
        state_d     = state;
        xm_d        = xm;
        n_d         = mm_n;
        a_d         = mm_a;
        b_d         = mm_b;
        start_d     = 1'b0;
        bit_out_d   = bit_out;
        bit_valid_d = bit_valid;
        err_d       = err;
`ifdef BBS_BYTE_EN
        cnt_d        = cnt;
        sh_d         = sh;
        byte_out_d   = byte_out;
        byte_valid_d = byte_valid;
`endif

        case (state)
            IDLE: begin
                if (seed_load) begin
`ifdef BBS_BYTE_EN
                    cnt_d = '0;
                    sh_d  = '0;
`endif
                    if (param_err_c) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        n_d     = n_mod;
                        a_d     = seed;
                        b_d     = r2;
                        start_d = 1'b1;
                        state_d = TO_MONT;
                    end
                end
            end
            TO_MONT: state_d = W_TM;
            W_TM: begin
                if (mm_done) begin
                    xm_d    = mm_res;
                    a_d     = mm_res;
                    b_d     = mm_res;
                    start_d = 1'b1;
                    state_d = SQ;
                end
            end
            SQ: state_d = W_SQ;
            W_SQ: begin
                if (mm_done) begin
                    xm_d    = mm_res;
                    a_d     = mm_res;
                    b_d     = M'(ONE_M);
                    start_d = 1'b1;
                    state_d = FM;
                end
            end
            FM: state_d = W_FM;
            W_FM: begin
                if (mm_done) begin
`ifdef BBS_BYTE_EN
                    sh_d  = {sh[BYTE_W-3:0], mm_res[0]};
                    cnt_d = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BYTE_W - 1)) begin
                        byte_out_d   = {sh, mm_res[0]};
                        byte_valid_d = 1'b1;
                        bit_out_d    = mm_res[0];
                        bit_valid_d  = 1'b1;
                        state_d      = EMIT;
                    end else begin
                        a_d     = xm;
                        b_d     = xm;
                        start_d = 1'b1;
                        state_d = SQ;
                    end
`else
                    bit_out_d   = mm_res[0];
                    bit_valid_d = 1'b1;
                    state_d     = EMIT;
`endif
                end
            end
            EMIT: begin
                // gen_en matters only on the accepting cycle
                if (bit_ready) begin
                    bit_valid_d = 1'b0;
`ifdef BBS_BYTE_EN
                    byte_valid_d = 1'b0;
`endif
                    if (gen_en) begin
                        a_d     = xm;
                        b_d     = xm;
                        start_d = 1'b1;
                        state_d = SQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_bbs_seq.sv
// Self-checking bench for bbs_seq with a variable-latency Montgomery multiplier model.
module tb_bbs_seq;

    localparam int unsigned M  = 8;
    localparam int          RV = 256;

    logic         clk, rst, seed_load, gen_en, bit_ready;
    logic [M-1:0] seed, n_mod, r2;
    logic         mm_start, mm_done, bit_out, bit_valid, busy, err;
    logic [M-1:0] mm_a, mm_b, mm_n, mm_res;
`ifdef BBS_BYTE_EN
    logic [7:0]   byte_out;
    logic         byte_valid;
`endif

    int checks = 0;
    int errors = 0;

    // multiplier model state
    int           op_cnt = 0;
    int           lat = 0;
    bit           pend = 0;
    bit           stray_req = 0;
    logic [M-1:0] ca, cb, cn;

    bbs_seq #(.M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .n_mod     (n_mod),
        .r2        (r2),
        .gen_en    (gen_en),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_n      (mm_n),
        .mm_done   (mm_done),
        .mm_res    (mm_res),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .busy      (busy),
`ifdef BBS_BYTE_EN
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
`endif
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a*b*R^-1 mod n, found by searching for k with k*R == a*b (mod n)
    function automatic int mont(input int a, input int b, input int n);
        int p;
        p = (a * b) % n;
        for (int k = 0; k < n; k++)
            if (((k * RV) % n) == p) return k;
        return 0;
    endfunction

    // Multiplier model: captures operands on mm_start, answers after 1..4 cycles.
    initial begin
        mm_done = 1'b0;
        mm_res  = '0;
        forever begin
            @(posedge clk);
            #1;
            mm_done = 1'b0;
            if (!rst) begin
                pend = 1'b0;
            end else if (pend) begin
                checks++;
                if (mm_a !== ca || mm_b !== cb || mm_start !== 1'b0) begin
                    errors++;
                    $display("FAIL op_hold a=%0d b=%0d start=%0b expected a=%0d b=%0d start=0",
                             mm_a, mm_b, mm_start, ca, cb);
                end
                lat--;
                if (lat == 0) begin
                    mm_done = 1'b1;
                    mm_res  = M'(mont(int'(ca), int'(cb), int'(cn)));
                    pend    = 1'b0;
                end
            end else if (mm_start) begin
                ca   = mm_a;
                cb   = mm_b;
                cn   = mm_n;
                lat  = int'($urandom_range(1, 4));
                pend = 1'b1;
                op_cnt++;
            end else if (stray_req) begin
                mm_done   = 1'b1;
                mm_res    = M'($urandom);
                stray_req = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int s, input int n, input int r);
        seed      = M'(s);
        n_mod     = M'(n);
        r2        = M'(r);
        seed_load = 1'b1;
        tick(1);
        seed_load = 1'b0;
    endtask

    task automatic wait_bit(output logic b, output bit ok);
        ok = 1'b0;
        b  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (bit_valid) begin
                b  = bit_out;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL bit_timeout no bit_valid within 300 cycles");
        end
    endtask

    task automatic drain();
        bit done;
        gen_en    = 1'b0;
        bit_ready = 1'b1;
        done      = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick(1);
            if (!busy && !bit_valid) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain busy=%0b still set, expected 0", busy);
        end
        gen_en = 1'b1;
    endtask

    task automatic test_reset();
        logic [4*M+4:0] obs;
        rst = 1'b1;
        seed_load = 1'b0; seed = '0; n_mod = '0; r2 = '0;
        gen_en = 1'b1; bit_ready = 1'b1;
        #1 rst = 1'b0;
        #3;
        obs = {mm_start, mm_a, mm_b, mm_n, bit_out, bit_valid, busy, err};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", obs);
        end
`ifdef BBS_BYTE_EN
        checks++;
        if ({byte_valid, byte_out} !== 9'd0) begin
            errors++;
            $display("FAIL reset_byte got %h expected 0", {byte_valid, byte_out});
        end
`endif
        tick(3);
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        logic b;
        bit   ok;
        int   x;
        int   k_exp [4] = '{1, 1, 0, 0};
        load(3, 209, 119);
        checks++;
        if (mm_n !== 8'd209 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_latch mm_n=%0d busy=%0b expected 209 1", mm_n, busy);
        end
        x = 3;
        for (int i = 0; i < 4; i++) begin
            x = (x * x) % 209;
            wait_bit(b, ok);
            checks++;
            if (b !== 1'((x & 1)) || b !== 1'(k_exp[i])) begin
                errors++;
                $display("FAIL basic_bit%0d got %0b expected %0d", i, b, x & 1);
            end
        end
        drain();
    endtask

    task automatic test_err();
        int bad_s [3] = '{3, 209, 1};
        int bad_n [3] = '{208, 209, 209};
        for (int i = 0; i < 3; i++) begin
            load(bad_s[i], bad_n[i], 119);
            tick(2);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL err_case%0d err=%0b busy=%0b expected 1 0", i, err, busy);
            end
        end
        load(3, 209, 119);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear err=%0b busy=%0b expected 0 1", err, busy);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic b;
        bit   ok;
        int   ops0, bad;
        bit_ready = 1'b0;
        load(3, 209, 119);
        wait_bit(b, ok);
        ops0 = op_cnt;
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bit_valid !== 1'b1 || bit_out !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold %0d cycles lost valid/bit, expected 0", bad);
        end
        checks++;
        if (op_cnt != ops0 || mm_start !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_issue ops=%0d expected %0d", op_cnt, ops0);
        end
        bit_ready = 1'b1;
        wait_bit(b, ok);
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got %0b expected 1", b);
        end
        drain();
    endtask

    task automatic test_stop();
        logic b1, b2, b3;
        bit   ok;
        int   extra;
        load(3, 209, 119);
        wait_bit(b1, ok);
        wait_bit(b2, ok);
        gen_en = 1'b0;
        extra  = 0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (bit_valid) extra++;
        end
        checks++;
        if (extra != 0 || busy !== 1'b0 || {b1, b2} !== 2'b11) begin
            errors++;
            $display("FAIL stop extra=%0d busy=%0b bits=%0b%0b expected 0 0 11", extra, busy, b1, b2);
        end
        gen_en = 1'b1;
        load(3, 209, 119);
        wait_bit(b3, ok);
        checks++;
        if (b3 !== 1'b1) begin
            errors++;
            $display("FAIL stop_reload got %0b expected 1", b3);
        end
        drain();
    endtask

    task automatic test_random();
        logic b;
        bit   ok;
        int   n, s, x;
        for (int t = 0; t < 5; t++) begin
            n = int'($urandom_range(5, 255)) | 1;
            s = int'($urandom_range(2, n - 1));
            load(s, n, (RV * RV) % n);
            x = s;
            for (int i = 0; i < 5; i++) begin
                x = (x * x) % n;
                wait_bit(b, ok);
                checks++;
                if (b !== 1'((x & 1))) begin
                    errors++;
                    $display("FAIL rand n=%0d s=%0d bit%0d got %0b expected %0d", n, s, i, b, x & 1);
                end
            end
            drain();
        end
    endtask

    task automatic test_reset_mid();
        logic [4*M+3:0] obs;
        int   ops0;
        bit   hit;
        ops0 = op_cnt;
        load(3, 209, 119);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick(1);
            if (op_cnt == ops0 + 2 && pend) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rst_mid never reached squaring op");
        end
        #2 rst = 1'b0;
        #1;
        obs = {mm_start, mm_a, mm_b, mm_n, bit_out, bit_valid, busy};
        checks++;
        if (obs !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got %h err=%0b expected 0", obs, err);
        end
        tick(3);
        rst = 1'b1;
        ops0 = op_cnt;
        stray_req = 1'b1;
        tick(8);
        checks++;
        if (busy !== 1'b0 || bit_valid !== 1'b0 || op_cnt != ops0 || stray_req !== 1'b0) begin
            errors++;
            $display("FAIL stray_done busy=%0b valid=%0b ops=%0d expected 0 0 %0d",
                     busy, bit_valid, op_cnt, ops0);
        end
    endtask

`ifdef BBS_BYTE_EN
    task automatic test_byte();
        int         x;
        logic [7:0] exp_b, got;
        bit         ok;
        load(3, 209, 119);
        x = 3;
        exp_b = '0;
        for (int i = 0; i < 8; i++) begin
            x = (x * x) % 209;
            exp_b = {exp_b[6:0], 1'((x & 1))};
        end
        ok = 1'b0;
        got = '0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            tick(1);
            if (byte_valid) begin
                ok  = 1'b1;
                got = byte_out;
            end
        end
        checks++;
        if (!ok || got !== exp_b) begin
            errors++;
            $display("FAIL byte got %h valid=%0b expected %h", got, ok, exp_b);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
`ifdef BBS_BYTE_EN
        test_err();
        test_byte();
`else
        test_basic();
        test_err();
        test_backpressure();
        test_stop();
        test_random();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
